// File: rtl/wb_dmem_pkg.sv
// Shared types and bus widths for the wb_dmem data-memory slave.
`timescale 1ns/1ps
package wb_dmem_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // Slave FSM: accept in IDLE, optional wait states, then a one-cycle ack or err.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_dmem_ram.sv
// Word-organised single-port RAM with byte-lane write enables and a registered read port.
// The array itself is not reset; only the read register is, so the bus data output
// starts at zero and clears with reset.
`timescale 1ns/1ps
module wb_dmem_ram
    import wb_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_re,
    input  logic [WB_SELW-1:0]             i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [WB_DW-1:0]               i_wdata,
    output logic [WB_DW-1:0]               o_rdata
);

    logic [WB_DW-1:0] r_mem [DEPTH_WORDS];
    logic [WB_DW-1:0] r_rdata;

    // Byte-lane write into the array; lanes with a clear enable keep their old contents.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WB_SELW; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register: loads only on a read request, otherwise holds the last word read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_dmem.sv
// Wishbone classic-cycle data-memory slave with programmable wait states.
// Handshake: a request is cyc_i & stb_i sampled in IDLE; the master holds it until
// exactly one of ack_o / err_o pulses for a single cycle. The slave always returns
// to IDLE for one cycle after a response, so a new request is only taken from there.
// The RAM access happens on the edge that enters RESP, so write data is committed
// and read data is registered by the time ack_o is seen.
`timescale 1ns/1ps
module wb_dmem
    import wb_dmem_pkg::*;
#(
    parameter logic [WB_AW-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               WAIT_STATES = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [WB_AW-1:0]   wbs_addr_i,
    input  logic [WB_SELW-1:0] wbs_sel_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    output logic [WB_DW-1:0]   wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o
);

    localparam int               IW      = $clog2(DEPTH_WORDS);
    localparam logic [WB_AW:0]   LIMIT   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]       WS_LOAD = 4'(WAIT_STATES - 1);

    // FSM state kept in one named register so checkers can bind to it directly.
    state_e              r_state;
    state_e              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [IW-1:0]       r_idx;
    logic [WB_SELW-1:0]  r_sel;
    logic [WB_DW-1:0]    r_wdata;

    logic                w_req;
    logic                w_valid;
    logic [WB_AW:0]      w_off;
    logic [IW-1:0]       w_idx;

    logic                w_ram_re;
    logic [WB_SELW-1:0]  w_ram_be;
    logic [IW-1:0]       w_ram_idx;
    logic [WB_DW-1:0]    w_ram_wdata;

    // Offset is computed one bit wider so an address below the base wraps to a value
    // with the top bit set and fails the single unsigned range compare.
    assign w_req   = wbs_cyc_i & wbs_stb_i;
    assign w_off   = {1'b0, wbs_addr_i} - {1'b0, ADDR_BASE};
    assign w_idx   = w_off[IW+1:2];
    assign w_valid = (wbs_addr_i[1:0] == 2'b00) && (w_off < LIMIT) && (wbs_sel_i != '0);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: accept/reject in IDLE, count down in WAIT, single-cycle responses.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_valid) begin
                        w_next = ERR;
                    end else if (WAIT_STATES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    w_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture on accept and wait-state countdown.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= (w_req && w_valid && (WAIT_STATES != 0)) ? WS_LOAD : 4'd0;
            if (w_req) begin
                r_we    <= wbs_we_i;
                r_idx   <= w_idx;
                r_sel   <= wbs_sel_i;
                r_wdata <= wbs_dat_i;
            end
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Outputs and RAM port: the access fires only on the edge entering RESP. With no
    // wait states that edge is the accept edge, so the live bus fields are used.
    always_comb begin
        wbs_ack_o   = (r_state == RESP);
        wbs_err_o   = (r_state == ERR);
        w_ram_re    = 1'b0;
        w_ram_be    = '0;
        w_ram_idx   = r_idx;
        w_ram_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_ram_idx   = w_idx;
            w_ram_wdata = wbs_dat_i;
        end
        if ((w_next == RESP) && (r_state != RESP)) begin
            if (r_state == IDLE) begin
                w_ram_re = ~wbs_we_i;
                w_ram_be = wbs_we_i ? wbs_sel_i : '0;
            end else begin
                w_ram_re = ~r_we;
                w_ram_be = r_we ? r_sel : '0;
            end
        end
    end

    wb_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_re    (w_ram_re),
        .i_be    (w_ram_be),
        .i_idx   (w_ram_idx),
        .i_wdata (w_ram_wdata),
        .o_rdata (wbs_dat_o)
    );

endmodule

// File: tb/tb_wb_dmem.sv
// Directed bench for wb_dmem: three instances with 0, 3 and 4 wait states share a clock
// and reset; a table of transfers runs on the zero-wait instance, hand sequences cover
// wait states, a dropped cycle and reset in the middle of a write.
`timescale 1ns/1ps
module tb_wb_dmem;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // per-instance bus signals: index 0 -> 0 WS, 1 -> 3 WS, 2 -> 4 WS
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] addr [3];
    logic [3:0]  sel  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        ack  [3];
    logic        err  [3];

    wb_dmem #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
        .wbs_addr_i(addr[0]), .wbs_sel_i(sel[0]), .wbs_dat_i(wdat[0]),
        .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));

    wb_dmem #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
        .wbs_addr_i(addr[1]), .wbs_sel_i(sel[1]), .wbs_dat_i(wdat[1]),
        .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));

    wb_dmem #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]), .wbs_we_i(we[2]),
        .wbs_addr_i(addr[2]), .wbs_sel_i(sel[2]), .wbs_dat_i(wdat[2]),
        .wbs_dat_o(rdat[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    // Issues one transfer and holds it until ack/err (bounded), then reports latency
    // counted in cycles after the accept cycle, the response kind, data, and whether
    // the response pulse lasted more than one cycle.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output logic got_err,
                        output logic [31:0] rd, output logic both, output logic extra);
        logic done;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdat[k] = d;
        lat = 0; got_err = 1'b0; rd = '0; both = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[k] && err[k]) both = 1'b1;
            if (ack[k] || err[k]) begin
                done = 1'b1; got_err = err[k]; rd = rdat[k];
            end
        end
        if (!done) lat = -1;
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); #1;
        extra = ack[k] | err[k];
    endtask

    task automatic run_check(input int k, input string name, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d, input logic exp_err,
                             input int exp_lat, input logic [31:0] exp_rd);
        int lat; logic ge; logic [31:0] rd; logic both; logic extra;
        xfer(k, w, a, s, d, lat, ge, rd, both, extra);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " err_vs_ack"}, {31'd0, ge}, {31'd0, exp_err});
        check({name, " ack_and_err"}, {31'd0, both}, 32'd0);
        check({name, " pulse_width"}, {31'd0, extra}, 32'd0);
        check({name, " dat_o"}, rd, exp_rd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;   // dat_o at response: read data, or the held value otherwise
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic seen;
        tbl[0]  = '{1'b1, 32'h0000_1008, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_1008, 4'hF, 32'h0000_0000, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h0000_1010, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 32'h0000_1010, 4'h5, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h0000_1010, 4'hF, 32'h0000_0000, 1'b0, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h0BADF00D, 1'b0, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 32'h0000_1040, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h11BB33DD};
        tbl[7]  = '{1'b1, 32'h0000_1002, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h11BB33DD};
        tbl[8]  = '{1'b1, 32'h0000_1000, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h11BB33DD};
        tbl[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h11BB33DD};
        tbl[10] = '{1'b0, 32'h0000_1040, 4'hF, 32'h0000_0000, 1'b1, 32'h11BB33DD};
        tbl[11] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 1'b0, 32'h0BADF00D};
        tbl[12] = '{1'b1, 32'h0000_103C, 4'hF, 32'h12345678, 1'b0, 32'h0BADF00D};
        tbl[13] = '{1'b0, 32'h0000_103C, 4'hF, 32'h0000_0000, 1'b0, 32'h12345678};
        tbl[14] = '{1'b0, 32'h0000_1008, 4'hF, 32'h0000_0000, 1'b0, 32'hDEADBEEF};
        tbl[15] = '{1'b1, 32'h0000_1000, 4'h8, 32'h77FFFFFF, 1'b0, 32'hDEADBEEF};
        tbl[16] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 1'b0, 32'h77ADF00D};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; sel[k] = '0; wdat[k] = '0;
        end
        #22;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ack[%0d]", k), {31'd0, ack[k]}, 32'd0);
            check($sformatf("reset err[%0d]", k), {31'd0, err[k]}, 32'd0);
            check($sformatf("reset dat[%0d]", k), rdat[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // table on the zero-wait instance: every response one cycle after accept
        for (int i = 0; i < 17; i++) begin
            run_check(0, $sformatf("v%0d", i), tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d,
                      tbl[i].e, 1, tbl[i].rd);
        end

        // three wait states: ack four cycles after accept, no err in between
        run_check(1, "ws3 write", 1'b1, BASE + 32'h4, 4'hF, 32'hCAFEF00D, 1'b0, 4, 32'h0);
        run_check(1, "ws3 read",  1'b0, BASE + 32'h4, 4'hF, 32'h0,        1'b0, 4, 32'hCAFEF00D);
        run_check(1, "ws3 oor",   1'b0, BASE + 32'h40, 4'hF, 32'h0,       1'b1, 1, 32'hCAFEF00D);

        // four wait states: commit a value, then abandon a write mid-wait
        run_check(2, "ws4 write", 1'b1, BASE + 32'h4, 4'hF, 32'h55AA55AA, 1'b0, 5, 32'h0);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE + 32'h4;
        sel[2] = 4'hF; wdat[2] = 32'hFFFFFFFF;
        @(posedge clk);           // accept
        @(posedge clk);           // wait cycle 1
        @(posedge clk); #1;       // wait cycle 2
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[2] | err[2];
        end
        check("drop no response", {31'd0, seen}, 32'd0);
        run_check(2, "drop readback", 1'b0, BASE + 32'h4, 4'hF, 32'h0, 1'b0, 5, 32'h55AA55AA);

        // reset during the wait of a write: outputs clear at once, word keeps old value
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE + 32'h4;
        sel[2] = 4'hF; wdat[2] = 32'h00000000;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst ack clear", {31'd0, ack[2]}, 32'd0);
        check("rst err clear", {31'd0, err[2]}, 32'd0);
        check("rst dat clear", rdat[2], 32'd0);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(2, "rst readback", 1'b0, BASE + 32'h4, 4'hF, 32'h0, 1'b0, 5, 32'h55AA55AA);
        run_check(2, "post write",   1'b1, BASE + 32'h8, 4'hF, 32'h600DCAFE, 1'b0, 5, 32'h55AA55AA);
        run_check(2, "post read",    1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0, 5, 32'h600DCAFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
